lcd_text_feeder: RTL and testbench

LCD_TEXT_FEEDER -- requirements
Module: lcd_text_feeder

---
 rtl/lcd_text_feeder_pkg.sv | 36 +++
 rtl/lcd_char_fifo.sv | 61 ++++++
 rtl/lcd_text_feeder.sv | 158 +++++++++++++++
 tb/tb_lcd_text_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_text_feeder_pkg.sv
// ---------------------------------------------------------------------------
// lcd_text_feeder_pkg : shared command, character-code and FSM definitions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcd_text_feeder_pkg;

  localparam logic [2:0] OP_INIT  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  localparam logic [7:0] c_CH_LF       = 8'h0A;
  localparam logic [7:0] c_CH_FF       = 8'h0C;
  localparam logic [7:0] c_CH_SPACE    = 8'h20;
  localparam logic [7:0] c_CH_PRINT_LO = 8'h20;
  localparam logic [7:0] c_CH_PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_WAIT_RDY0 = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_IDLE      = 3'd4,
    ST_POP       = 3'd5,
    ST_DECODE    = 3'd6,
    ST_PAD       = 3'd7
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= c_CH_PRINT_LO) && (b <= c_CH_PRINT_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_char_fifo.sv
// ---------------------------------------------------------------------------
// lcd_char_fifo : power-of-two synchronous FIFO with occupancy count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == c_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_text_feeder.sv
// ---------------------------------------------------------------------------
// lcd_text_feeder : buffers text bytes and turns them into one-hot LCD commands
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_text_feeder
  import lcd_text_feeder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int COLS      = 16,
  parameter int NCOMMANDS = 5,
  parameter int HOLDOFF   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic                   lcd_rdy,
  output logic [NCOMMANDS:0]     op_out,
  output logic [7:0]             data_out,
  output logic                   enable,
  output logic                   init_done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                 c_COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int                 c_HLD_W     = $clog2(HOLDOFF + 1);
  localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(COLS - 1);
  localparam logic [c_HLD_W-1:0] c_HOLD_LAST = c_HLD_W'(HOLDOFF - 1);

  state_t               r_state;
  logic [2:0]           r_op;
  logic [7:0]           r_data;
  logic                 r_enable;
  logic                 r_init_done;
  logic [c_COL_W-1:0]   r_col;
  logic [c_HLD_W-1:0]   r_hold_cnt;
  logic [7:0]           r_char;
  logic                 r_pad;

  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic [7:0]           w_fifo_dout;
  logic                 w_full;
  logic                 w_empty;
  logic [c_COL_W-1:0]   w_col_next;

  assign char_ready  = ~w_full & r_init_done;
  assign w_fifo_push = char_valid & char_ready;
  assign w_fifo_pop  = (r_state == ST_POP);
  assign w_col_next  = (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;

  assign op_out    = {{(NCOMMANDS-2){1'b0}}, r_op};
  assign data_out  = r_data;
  assign enable    = r_enable;
  assign init_done = r_init_done;

  lcd_char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_din   (char_in),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // enable is raised on the transition into ISSUE so it is high exactly while ISSUE is current
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_WAIT_RDY0;
      r_op        <= '0;
      r_data      <= '0;
      r_enable    <= 1'b0;
      r_init_done <= 1'b0;
      r_col       <= '0;
      r_hold_cnt  <= '0;
      r_char      <= '0;
      r_pad       <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        ST_WAIT_RDY0: begin
          if (lcd_rdy) begin
            r_op     <= OP_INIT;
            r_data   <= '0;
            r_enable <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_hold_cnt <= '0;
          r_state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold_cnt == c_HOLD_LAST) r_state <= ST_WAIT_DONE;
          else                           r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (lcd_rdy) begin
            r_init_done <= 1'b1;
            if (r_pad && (r_col != '0)) begin
              r_state <= ST_PAD;
            end else begin
              r_pad   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_POP;
        end
        ST_POP: begin
          r_char  <= w_fifo_dout;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_printable(r_char)) begin
            r_op     <= OP_WRITE;
            r_data   <= r_char;
            r_col    <= w_col_next;
            r_enable <= 1'b1;
            r_state  <= ST_ISSUE;
          end else if (r_char == c_CH_FF) begin
            r_op     <= OP_CLEAR;
            r_data   <= '0;
            r_col    <= '0;
            r_enable <= 1'b1;
            r_state  <= ST_ISSUE;
          end else if ((r_char == c_CH_LF) && (r_col != '0)) begin
            r_pad   <= 1'b1;
            r_state <= ST_PAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PAD: begin
          r_op     <= OP_WRITE;
          r_data   <= c_CH_SPACE;
          r_col    <= w_col_next;
          r_enable <= 1'b1;
          r_state  <= ST_ISSUE;
        end
        default: r_state <= ST_WAIT_RDY0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_feeder.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_feeder : randomized self-checking bench with a text-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_text_feeder;

  localparam int DEPTH     = 16;
  localparam int COLS      = 16;
  localparam int NCOMMANDS = 5;
  localparam int HOLDOFF   = 4;

  localparam logic [5:0] c_OPI = 6'b000001;
  localparam logic [5:0] c_OPW = 6'b000010;
  localparam logic [5:0] c_OPC = 6'b000100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       lcd_rdy;
  logic [5:0] op_out;
  logic [7:0] data_out;
  logic       enable;
  logic       init_done;
  logic [4:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] mon_q[$];
  logic [13:0] exp_q[$];
  int          m_col;
  bit          rand_rdy;

  always #5 clk = ~clk;

  lcd_text_feeder #(
    .DEPTH(DEPTH), .COLS(COLS), .NCOMMANDS(NCOMMANDS), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .lcd_rdy(lcd_rdy), .op_out(op_out),
    .data_out(data_out), .enable(enable), .init_done(init_done), .level(level)
  );

  always @(negedge clk) begin
    if (enable === 1'b1) mon_q.push_back({op_out, data_out});
  end

  // Text-level reference: what an LCD should be told for each byte
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({c_OPW, b});
      m_col = (m_col + 1) % COLS;
    end else if (b == 8'h0C) begin
      exp_q.push_back({c_OPC, 8'h00});
      m_col = 0;
    end else if (b == 8'h0A) begin
      if (m_col != 0) repeat (COLS - m_col) exp_q.push_back({c_OPW, 8'h20});
      m_col = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) lcd_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int budget;
    budget = 500;
    ok = 1'b0;
    char_in = b;
    char_valid = 1'b1;
    while (budget > 0 && !ok) begin
      if (char_ready) ok = 1'b1;
      tick();
      budget--;
    end
    char_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL push_timeout byte=%h char_ready stayed %b", b, char_ready);
    end
  endtask

  task automatic wait_quiet(input string tag);
    int quiet;
    int budget;
    quiet = 0;
    budget = 3000;
    while (quiet < 12 && budget > 0) begin
      tick();
      budget--;
      if (enable === 1'b0 && level == 0) quiet++;
      else quiet = 0;
    end
    n_checks++;
    if (quiet < 12) begin
      n_errors++;
      $display("FAIL %s_drain_timeout level=%0d required 0", tag, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; char_valid = 1'b0; char_in = 8'h00; lcd_rdy = 1'b0; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 6;
    if (enable !== 1'b0)     begin n_errors++; $display("FAIL rst_enable got=%b exp=0", enable); end
    if (op_out !== 6'd0)     begin n_errors++; $display("FAIL rst_op got=%b exp=000000", op_out); end
    if (data_out !== 8'd0)   begin n_errors++; $display("FAIL rst_data got=%h exp=00", data_out); end
    if (init_done !== 1'b0)  begin n_errors++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    if (char_ready !== 1'b0) begin n_errors++; $display("FAIL rst_char_ready got=%b exp=0", char_ready); end
    if (level !== 5'd0)      begin n_errors++; $display("FAIL rst_level got=%0d exp=0", level); end
  endtask

  task automatic test_init();
    int base;
    int budget;
    rst = 1'b1;
    lcd_rdy = 1'b0;
    base = mon_q.size();
    repeat (6) tick();
    n_checks++;
    if (mon_q.size() != base) begin n_errors++; $display("FAIL init_before_rdy cmds=%0d exp=0", mon_q.size() - base); end
    lcd_rdy = 1'b1;
    budget = 20;
    while (enable !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_checks++;
    if (enable !== 1'b1) begin n_errors++; $display("FAIL init_enable_timeout enable=%b exp=1", enable); end
    lcd_rdy = 1'b0;
    repeat (HOLDOFF + 6) tick();
    n_checks += 3;
    if (init_done !== 1'b0) begin n_errors++; $display("FAIL init_done_early got=%b exp=0", init_done); end
    if (mon_q.size() != base + 1) begin n_errors++; $display("FAIL init_pulses got=%0d exp=1", mon_q.size() - base); end
    else if (mon_q[base] !== {c_OPI, 8'h00}) begin n_errors++; $display("FAIL init_cmd got=%h exp=%h", mon_q[base], {c_OPI, 8'h00}); end
    lcd_rdy = 1'b1;
    budget = 5;
    while (init_done !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_checks += 2;
    if (init_done !== 1'b1)  begin n_errors++; $display("FAIL init_done got=%b exp=1", init_done); end
    if (char_ready !== 1'b1) begin n_errors++; $display("FAIL init_char_ready got=%b exp=1", char_ready); end
    m_col = 0;
  endtask

  task automatic test_hi();
    int base;
    bit ok;
    base = mon_q.size();
    exp_q.delete();
    lcd_rdy = 1'b0;
    push_byte(8'h48, ok); if (ok) model_byte(8'h48);
    tick(); tick();
    n_checks++;
    if (enable !== 1'b0) begin n_errors++; $display("FAIL latency_early enable=%b exp=0", enable); end
    tick();
    n_checks++;
    if (enable !== 1'b1) begin n_errors++; $display("FAIL latency_4 enable=%b exp=1", enable); end
    push_byte(8'h69, ok); if (ok) model_byte(8'h69);
    repeat (20) tick();
    n_checks += 2;
    if (mon_q.size() - base != 1) begin n_errors++; $display("FAIL hi_gated cmds=%0d exp=1", mon_q.size() - base); end
    if ({op_out, data_out} !== {c_OPW, 8'h48}) begin n_errors++; $display("FAIL hi_held got=%h exp=%h", {op_out, data_out}, {c_OPW, 8'h48}); end
    lcd_rdy = 1'b1;
    wait_quiet("hi");
    n_checks += 2;
    if (mon_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL hi_count got=%0d exp=%0d", mon_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base+i] !== exp_q[i]) begin n_errors++; $display("FAIL hi_cmd[%0d] got=%h exp=%h", i, mon_q[base+i], exp_q[i]); end
    end
    if (int'(dut.r_col) != m_col) begin n_errors++; $display("FAIL hi_col got=%0d exp=%0d", dut.r_col, m_col); end
  endtask

  task automatic test_pad();
    int base;
    int spaces;
    bit ok;
    base = mon_q.size();
    exp_q.delete();
    push_byte(8'h61, ok); if (ok) model_byte(8'h61);
    push_byte(8'h0A, ok); if (ok) model_byte(8'h0A);
    wait_quiet("pad");
    spaces = 0;
    for (int i = base; i < mon_q.size(); i++) if (mon_q[i] === {c_OPW, 8'h20}) spaces++;
    n_checks += 3;
    if (spaces != 13) begin n_errors++; $display("FAIL pad_spaces got=%0d exp=13", spaces); end
    if (mon_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL pad_count got=%0d exp=%0d", mon_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base+i] !== exp_q[i]) begin n_errors++; $display("FAIL pad_cmd[%0d] got=%h exp=%h", i, mon_q[base+i], exp_q[i]); end
    end
    if (int'(dut.r_col) != 0) begin n_errors++; $display("FAIL pad_col got=%0d exp=0", dut.r_col); end
    base = mon_q.size();
    push_byte(8'h0A, ok); if (ok) model_byte(8'h0A);
    wait_quiet("lf0");
    n_checks++;
    if (mon_q.size() != base) begin n_errors++; $display("FAIL lf_col0 cmds=%0d exp=0", mon_q.size() - base); end
  endtask

  task automatic test_clear_drop();
    int base;
    bit ok;
    base = mon_q.size();
    exp_q.delete();
    push_byte(8'h78, ok); if (ok) model_byte(8'h78);
    push_byte(8'h0C, ok); if (ok) model_byte(8'h0C);
    wait_quiet("clr");
    n_checks += 2;
    if (mon_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL clr_count got=%0d exp=%0d", mon_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base+i] !== exp_q[i]) begin n_errors++; $display("FAIL clr_cmd[%0d] got=%h exp=%h", i, mon_q[base+i], exp_q[i]); end
    end
    if (int'(dut.r_col) != m_col) begin n_errors++; $display("FAIL clr_col got=%0d exp=%0d", dut.r_col, m_col); end
    base = mon_q.size();
    push_byte(8'h07, ok); if (ok) model_byte(8'h07);
    n_checks++;
    if (level !== 5'd1) begin n_errors++; $display("FAIL drop_level_in got=%0d exp=1", level); end
    repeat (4) tick();
    n_checks++;
    if (level !== 5'd0) begin n_errors++; $display("FAIL drop_level_out got=%0d exp=0", level); end
    wait_quiet("drop");
    n_checks++;
    if (mon_q.size() != base) begin n_errors++; $display("FAIL drop_cmds got=%0d exp=0", mon_q.size() - base); end
  endtask

  task automatic test_full();
    int base;
    int budget;
    int accepted;
    logic [7:0] b;
    logic [4:0] lvl_before;
    bit ok;
    base = mon_q.size();
    exp_q.delete();
    lcd_rdy = 1'b0;
    push_byte(8'h5A, ok); if (ok) model_byte(8'h5A);
    budget = 20;
    while (enable !== 1'b1 && budget > 0) begin tick(); budget--; end
    accepted = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(32, 126));
      char_in = b;
      char_valid = 1'b1;
      if (char_ready) begin accepted++; model_byte(b); end
      tick();
    end
    char_valid = 1'b0;
    n_checks += 3;
    if (accepted != 16)      begin n_errors++; $display("FAIL full_accepted got=%0d exp=16", accepted); end
    if (level !== 5'd16)     begin n_errors++; $display("FAIL full_level got=%0d exp=16", level); end
    if (char_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready got=%b exp=0", char_ready); end
    lcd_rdy = 1'b1;
    budget = 40;
    while (dut.w_fifo_pop !== 1'b1 && budget > 0) begin tick(); budget--; end
    tick();
    budget = 40;
    while (dut.w_fifo_pop !== 1'b1 && budget > 0) begin tick(); budget--; end
    b = 8'($urandom_range(32, 126));
    char_in = b;
    char_valid = 1'b1;
    lvl_before = level;
    if (char_ready) model_byte(b);
    tick();
    char_valid = 1'b0;
    n_checks++;
    if (level !== lvl_before || lvl_before !== 5'd15) begin
      n_errors++; $display("FAIL pushpop_level got=%0d before=%0d exp=15", level, lvl_before);
    end
    wait_quiet("full");
    n_checks++;
    if (mon_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL full_count got=%0d exp=%0d", mon_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base+i] !== exp_q[i]) begin n_errors++; $display("FAIL full_cmd[%0d] got=%h exp=%h", i, mon_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int base;
    int r;
    logic [7:0] b;
    bit ok;
    base = mon_q.size();
    exp_q.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'h0A;
      else if (r == 1) b = 8'h0C;
      else if (r == 2) b = 8'($urandom_range(0, 255));
      else             b = 8'($urandom_range(32, 126));
      push_byte(b, ok);
      if (ok) model_byte(b);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rdy = 1'b0;
    lcd_rdy = 1'b1;
    wait_quiet("rand");
    n_checks += 2;
    if (mon_q.size() - base != exp_q.size()) begin n_errors++; $display("FAIL rand_count got=%0d exp=%0d", mon_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[base+i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_cmd[%0d] got=%h exp=%h", i, mon_q[base+i], exp_q[i]); end
    end
    if (int'(dut.r_col) != m_col) begin n_errors++; $display("FAIL rand_col got=%0d exp=%0d", dut.r_col, m_col); end
  endtask

  task automatic test_reset_mid_pad();
    int base;
    int budget;
    bit ok;
    base = mon_q.size();
    lcd_rdy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h71, ok);
    push_byte(8'h0A, ok);
    for (int i = 0; i < 3; i++) push_byte(8'h72, ok);
    budget = 300;
    while (mon_q.size() < base + 8 && budget > 0) begin tick(); budget--; end
    #1 rst = 1'b0;
    #1;
    n_checks += 7;
    if (enable !== 1'b0)     begin n_errors++; $display("FAIL mid_enable got=%b exp=0", enable); end
    if (op_out !== 6'd0)     begin n_errors++; $display("FAIL mid_op got=%b exp=000000", op_out); end
    if (data_out !== 8'd0)   begin n_errors++; $display("FAIL mid_data got=%h exp=00", data_out); end
    if (init_done !== 1'b0)  begin n_errors++; $display("FAIL mid_init_done got=%b exp=0", init_done); end
    if (char_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready got=%b exp=0", char_ready); end
    if (level !== 5'd0)      begin n_errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    if (int'(dut.r_col) != 0) begin n_errors++; $display("FAIL mid_col got=%0d exp=0", dut.r_col); end
    tick(); tick();
    rst = 1'b1;
    m_col = 0;
    base = mon_q.size();
    budget = 40;
    while (init_done !== 1'b1 && budget > 0) begin tick(); budget--; end
    wait_quiet("post_rst");
    n_checks += 3;
    if (init_done !== 1'b1) begin n_errors++; $display("FAIL post_init_done got=%b exp=1", init_done); end
    if (mon_q.size() - base != 1) begin n_errors++; $display("FAIL post_cmds got=%0d exp=1", mon_q.size() - base); end
    else if (mon_q[base] !== {c_OPI, 8'h00}) begin n_errors++; $display("FAIL post_cmd got=%h exp=%h", mon_q[base], {c_OPI, 8'h00}); end
    if (level !== 5'd0) begin n_errors++; $display("FAIL post_level got=%0d exp=0", level); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_hi();
    test_pad();
    test_clear_drop();
    test_full();
    test_random();
    test_reset_mid_pad();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
